// File: rtl/cdb_rr_arbiter_if.sv
// cdb_rr_arbiter_if: CDB packet type and the unit/commit/bus bundle between functional units and the arbiter
`ifndef CDB_RR_ARBITER_IF_SV
`define CDB_RR_ARBITER_IF_SV
typedef struct packed {
  logic [3:0]  dest_ROB_entry;
  logic [31:0] result;
  logic        branch_result;
  logic        from_commit;
} CDB_packet_t;

interface cdb_rr_arbiter_if;
  logic [5:0]  valid_out_bus;
  CDB_packet_t adder_0_out;
  CDB_packet_t adder_1_out;
  CDB_packet_t mult_out;
  CDB_packet_t div_out;
  CDB_packet_t mem_out;
  CDB_packet_t shift_out;
  CDB_packet_t commit_packet;
  logic [5:0]  yummi_in_bus;
  CDB_packet_t new_CDB;
  logic [2:0]  rr_ptr_o;
`ifdef CDB_ARB_STATS_EN
  logic [15:0] grant_cnt [6];
  logic [15:0] commit_stall_cnt;
  logic [15:0] starve_grant_cnt;
  modport master (
    output valid_out_bus, adder_0_out, adder_1_out, mult_out, div_out, mem_out, shift_out, commit_packet,
    input  yummi_in_bus, new_CDB, rr_ptr_o, grant_cnt, commit_stall_cnt, starve_grant_cnt
  );
  modport slave (
    input  valid_out_bus, adder_0_out, adder_1_out, mult_out, div_out, mem_out, shift_out, commit_packet,
    output yummi_in_bus, new_CDB, rr_ptr_o, grant_cnt, commit_stall_cnt, starve_grant_cnt
  );
`else
  modport master (
    output valid_out_bus, adder_0_out, adder_1_out, mult_out, div_out, mem_out, shift_out, commit_packet,
    input  yummi_in_bus, new_CDB, rr_ptr_o
  );
  modport slave (
    input  valid_out_bus, adder_0_out, adder_1_out, mult_out, div_out, mem_out, shift_out, commit_packet,
    output yummi_in_bus, new_CDB, rr_ptr_o
  );
`endif
endinterface
`endif

// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: commit-first, starvation-aware round-robin CDB arbiter with registered bus; CDB_ARB_STATS_EN adds grant/stall/starve counters
module cdb_rr_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic reset,
  cdb_rr_arbiter_if.slave bus
);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);
  CDB_packet_t pkt [6];
  CDB_packet_t cdb;
  logic [AGE_W-1:0] age [6];
  logic [5:0] valid, yummi;
  logic [2:0] rr_ptr, rr_idx, starve_idx, gnt_idx;
  logic starve_any, commit_win, unit_gnt;

  function automatic logic [2:0] wrap(input logic [3:0] s);
    return s >= 4'd6 ? 3'(s - 4'd6) : s[2:0];
  endfunction

  assign valid = bus.valid_out_bus;
  assign pkt = '{bus.adder_0_out, bus.adder_1_out, bus.mult_out, bus.div_out, bus.mem_out, bus.shift_out};
  assign commit_win = |bus.commit_packet.dest_ROB_entry;

  // lowest-index starved unit, and first valid unit scanning up from the pointer
  always_comb begin
    starve_any = 1'b0;
    starve_idx = '0;
    rr_idx = '0;
    for (int i = 5; i >= 0; i--)
      if (valid[i] && age[i] >= LIMIT) begin
        starve_any = 1'b1;
        starve_idx = 3'(i);
      end
    for (int k = 5; k >= 0; k--)
      if (valid[wrap({1'b0, rr_ptr} + 4'(k))]) rr_idx = wrap({1'b0, rr_ptr} + 4'(k));
  end

  assign gnt_idx = starve_any ? starve_idx : rr_idx;
  assign unit_gnt = !reset && !commit_win && |valid;
  assign yummi = unit_gnt ? 6'd1 << gnt_idx : 6'd0;
  assign bus.yummi_in_bus = yummi;
  assign bus.new_CDB = cdb;
  assign bus.rr_ptr_o = rr_ptr;

  // bus register, pointer advance past the winner, saturating per-unit wait ages
  always_ff @(posedge clk) begin
    if (reset) begin
      cdb <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < 6; i++) age[i] <= '0;
    end else begin
      cdb <= commit_win ? bus.commit_packet : unit_gnt ? pkt[gnt_idx] : '0;
      if (unit_gnt) rr_ptr <= gnt_idx == 3'd5 ? 3'd0 : gnt_idx + 3'd1;
      for (int i = 0; i < 6; i++)
        age[i] <= !valid[i] || yummi[i] ? '0 : age[i] == LIMIT ? age[i] : age[i] + 1'b1;
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [15:0] grant_cnt [6];
  logic [15:0] commit_stall_cnt, starve_grant_cnt;

  // free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) grant_cnt[i] <= '0;
      commit_stall_cnt <= '0;
      starve_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < 6; i++) if (yummi[i]) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      if (commit_win && |valid) commit_stall_cnt <= commit_stall_cnt + 16'd1;
      if (unit_gnt && starve_any) starve_grant_cnt <= starve_grant_cnt + 16'd1;
    end
  end

  assign bus.grant_cnt = grant_cnt;
  assign bus.commit_stall_cnt = commit_stall_cnt;
  assign bus.starve_grant_cnt = starve_grant_cnt;
`endif
endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// tb_cdb_rr_arbiter: directed and randomized checks of the CDB arbiter against a behavioural model
module tb_cdb_rr_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cdb_rr_arbiter_if if0();
  cdb_rr_arbiter_if if1();
  logic [5:0] v0, v1;
  CDB_packet_t p0 [6];
  CDB_packet_t p1 [6];
  CDB_packet_t c0, c1;

  assign if0.valid_out_bus = v0;
  assign if0.adder_0_out = p0[0];
  assign if0.adder_1_out = p0[1];
  assign if0.mult_out = p0[2];
  assign if0.div_out = p0[3];
  assign if0.mem_out = p0[4];
  assign if0.shift_out = p0[5];
  assign if0.commit_packet = c0;
  assign if1.valid_out_bus = v1;
  assign if1.adder_0_out = p1[0];
  assign if1.adder_1_out = p1[1];
  assign if1.mult_out = p1[2];
  assign if1.div_out = p1[3];
  assign if1.mem_out = p1[4];
  assign if1.shift_out = p1[5];
  assign if1.commit_packet = c1;

  cdb_rr_arbiter u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  cdb_rr_arbiter #(.STARVE_LIMIT(2)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr;
  int m_age [6];
  CDB_packet_t m_cdb;

  function automatic CDB_packet_t rand_pkt();
    CDB_packet_t p;
    p.dest_ROB_entry = 4'($urandom_range(1, 15));
    p.result = $urandom;
    p.branch_result = 1'($urandom_range(0, 1));
    p.from_commit = 1'($urandom_range(0, 1));
    return p;
  endfunction

  function automatic int model_grant();
    if (reset || c0.dest_ROB_entry != 4'd0) return -1;
    for (int i = 0; i < 6; i++) if (v0[i] && m_age[i] >= 8) return i;
    for (int k = 0; k < 6; k++) if (v0[(m_ptr + k) % 6]) return (m_ptr + k) % 6;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    v0 = 6'h3f;
    c0 = '0;
    v1 = '0;
    c1 = '0;
    for (int i = 0; i < 6; i++) begin
      p0[i] = rand_pkt();
      p1[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (if0.yummi_in_bus !== 6'd0) begin n_err++; $display("FAIL reset_yummi got %b want 000000", if0.yummi_in_bus); end
    n_cmp++; if (if0.new_CDB !== '0) begin n_err++; $display("FAIL reset_cdb got %h want 0", if0.new_CDB); end
    n_cmp++; if (if0.rr_ptr_o !== 3'd0) begin n_err++; $display("FAIL reset_ptr got %0d want 0", if0.rr_ptr_o); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (if0.yummi_in_bus !== 6'b000001) begin n_err++; $display("FAIL first_grant got %b want 000001", if0.yummi_in_bus); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (if0.new_CDB !== p0[0]) begin n_err++; $display("FAIL first_cdb got %h want %h", if0.new_CDB, p0[0]); end
    n_cmp++; if (if0.rr_ptr_o !== 3'd1) begin n_err++; $display("FAIL first_ptr got %0d want 1", if0.rr_ptr_o); end
  endtask

  task automatic test_round_robin();
    CDB_packet_t exp_pkt;
    int g;
    for (int k = 0; k < 12; k++) begin
      g = (1 + k) % 6;
      n_cmp++; if (if0.yummi_in_bus !== 6'(1 << g)) begin n_err++; $display("FAIL rr_yummi k=%0d got %b want %b", k, if0.yummi_in_bus, 6'(1 << g)); end
      if (k > 0) begin
        n_cmp++; if (if0.new_CDB !== exp_pkt) begin n_err++; $display("FAIL rr_cdb k=%0d got %h want %h", k, if0.new_CDB, exp_pkt); end
      end
      exp_pkt = p0[g];
      @(posedge clk); #1 p0[g] = rand_pkt();
      @(negedge clk);
    end
    n_cmp++; if (if0.new_CDB !== exp_pkt) begin n_err++; $display("FAIL rr_cdb_last got %h want %h", if0.new_CDB, exp_pkt); end
    n_cmp++; if (if0.rr_ptr_o !== 3'd1) begin n_err++; $display("FAIL rr_ptr got %0d want 1", if0.rr_ptr_o); end
  endtask

  task automatic test_commit_starve();
    CDB_packet_t cs;
    @(posedge clk); #1;
    v0 = 6'b001000;
    c0 = rand_pkt();
    c0.dest_ROB_entry = 4'd3;
    cs = c0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++; if (if0.yummi_in_bus !== 6'd0) begin n_err++; $display("FAIL commit_yummi k=%0d got %b want 000000", k, if0.yummi_in_bus); end
      if (k > 0) begin
        n_cmp++; if (if0.new_CDB !== cs) begin n_err++; $display("FAIL commit_cdb k=%0d got %h want %h", k, if0.new_CDB, cs); end
      end
      @(posedge clk); #1;
    end
    c0 = '0;
    @(negedge clk);
    n_cmp++; if (if0.new_CDB !== cs) begin n_err++; $display("FAIL commit_cdb_end got %h want %h", if0.new_CDB, cs); end
    n_cmp++; if (if0.yummi_in_bus !== 6'b001000) begin n_err++; $display("FAIL div_release got %b want 001000", if0.yummi_in_bus); end
    @(posedge clk); #1 v0 = '0;
    @(negedge clk);
    n_cmp++; if (if0.new_CDB !== p0[3]) begin n_err++; $display("FAIL div_cdb got %h want %h", if0.new_CDB, p0[3]); end
    n_cmp++; if (if0.rr_ptr_o !== 3'd4) begin n_err++; $display("FAIL div_ptr got %0d want 4", if0.rr_ptr_o); end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (if0.new_CDB !== '0) begin n_err++; $display("FAIL idle_cdb k=%0d got %h want 0", k, if0.new_CDB); end
      n_cmp++; if (if0.rr_ptr_o !== 3'd4) begin n_err++; $display("FAIL idle_ptr k=%0d got %0d want 4", k, if0.rr_ptr_o); end
      n_cmp++; if (if0.yummi_in_bus !== 6'd0) begin n_err++; $display("FAIL idle_yummi k=%0d got %b want 000000", k, if0.yummi_in_bus); end
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1 v0 = 6'h3f;
    @(negedge clk);
    n_cmp++; if (if0.yummi_in_bus !== 6'b010000) begin n_err++; $display("FAIL pre_reset_yummi got %b want 010000", if0.yummi_in_bus); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (if0.yummi_in_bus !== 6'd0) begin n_err++; $display("FAIL mid_reset_yummi got %b want 000000", if0.yummi_in_bus); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (if0.new_CDB !== '0) begin n_err++; $display("FAIL mid_reset_cdb got %h want 0", if0.new_CDB); end
    n_cmp++; if (if0.rr_ptr_o !== 3'd0) begin n_err++; $display("FAIL mid_reset_ptr got %0d want 0", if0.rr_ptr_o); end
    @(posedge clk); #1;
    reset = 1'b0;
    v0 = '0;
  endtask

  task automatic test_starve_override();
    @(posedge clk); #1 v1 = 6'b010000;
    @(negedge clk);
    n_cmp++; if (if1.yummi_in_bus !== 6'b010000) begin n_err++; $display("FAIL s_mem got %b want 010000", if1.yummi_in_bus); end
    @(posedge clk); #1;
    v1 = 6'b100010;
    c1 = '0;
    c1.dest_ROB_entry = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (if1.yummi_in_bus !== 6'd0) begin n_err++; $display("FAIL s_commit k=%0d got %b want 000000", k, if1.yummi_in_bus); end
      @(posedge clk); #1;
    end
    c1 = '0;
    @(negedge clk);
    n_cmp++; if (if1.rr_ptr_o !== 3'd5) begin n_err++; $display("FAIL s_ptr5 got %0d want 5", if1.rr_ptr_o); end
    n_cmp++; if (if1.yummi_in_bus !== 6'b000010) begin n_err++; $display("FAIL s_override got %b want 000010", if1.yummi_in_bus); end
    @(posedge clk); #1 v1 = 6'b100000;
    @(negedge clk);
    n_cmp++; if (if1.rr_ptr_o !== 3'd2) begin n_err++; $display("FAIL s_ptr2 got %0d want 2", if1.rr_ptr_o); end
    n_cmp++; if (if1.yummi_in_bus !== 6'b100000) begin n_err++; $display("FAIL s_second got %b want 100000", if1.yummi_in_bus); end
    @(posedge clk); #1 v1 = 6'b001000;
    @(negedge clk);
    n_cmp++; if (if1.yummi_in_bus !== 6'b001000) begin n_err++; $display("FAIL s_div got %b want 001000", if1.yummi_in_bus); end
    @(posedge clk); #1;
    v1 = 6'b101000;
    c1.dest_ROB_entry = 4'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (if1.yummi_in_bus !== 6'd0) begin n_err++; $display("FAIL s_commit2 k=%0d got %b want 000000", k, if1.yummi_in_bus); end
      @(posedge clk); #1;
    end
    c1 = '0;
    @(negedge clk);
    n_cmp++; if (if1.rr_ptr_o !== 3'd4) begin n_err++; $display("FAIL s_ptr4 got %0d want 4", if1.rr_ptr_o); end
    n_cmp++; if (if1.yummi_in_bus !== 6'b001000) begin n_err++; $display("FAIL s_saturate got %b want 001000", if1.yummi_in_bus); end
    @(posedge clk); #1 v1 = '0;
  endtask

  task automatic test_random();
    int g;
    bit commit_on = 1'b0;
    reset = 1'b1;
    v0 = '0;
    c0 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_ptr = 0;
    m_cdb = '0;
    for (int i = 0; i < 6; i++) m_age[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      g = model_grant();
      n_cmp++; if (if0.yummi_in_bus !== (g < 0 ? 6'd0 : 6'(1 << g))) begin n_err++; $display("FAIL rand_yummi cyc=%0d got %b want grant %0d", cyc, if0.yummi_in_bus, g); end
      n_cmp++; if (if0.new_CDB !== m_cdb) begin n_err++; $display("FAIL rand_cdb cyc=%0d got %h want %h", cyc, if0.new_CDB, m_cdb); end
      n_cmp++; if (if0.rr_ptr_o !== 3'(m_ptr)) begin n_err++; $display("FAIL rand_ptr cyc=%0d got %0d want %0d", cyc, if0.rr_ptr_o, m_ptr); end
      @(posedge clk);
      m_cdb = c0.dest_ROB_entry != 4'd0 ? c0 : g >= 0 ? p0[g] : '0;
      if (g >= 0) m_ptr = (g + 1) % 6;
      for (int i = 0; i < 6; i++) m_age[i] = (!v0[i] || g == i) ? 0 : (m_age[i] < 8 ? m_age[i] + 1 : 8);
      #1;
      for (int i = 0; i < 6; i++)
        if (v0[i] && g == i) begin
          v0[i] = 1'($urandom_range(0, 1));
          p0[i] = rand_pkt();
        end else if (!v0[i] && $urandom_range(0, 2) == 0) begin
          v0[i] = 1'b1;
          p0[i] = rand_pkt();
        end
      if ($urandom_range(0, 7) == 0) commit_on = !commit_on;
      c0 = commit_on ? rand_pkt() : '0;
    end
    v0 = '0;
    c0 = '0;
  endtask

`ifdef CDB_ARB_STATS_EN
  task automatic test_stats();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    v0 = 6'b001000;
    c0 = rand_pkt();
    c0.dest_ROB_entry = 4'd3;
    repeat (10) @(posedge clk);
    #1 c0 = '0;
    @(posedge clk); #1 v0 = '0;
    @(negedge clk);
    n_cmp++; if (if0.commit_stall_cnt !== 16'd10) begin n_err++; $display("FAIL stall_cnt got %0d want 10", if0.commit_stall_cnt); end
    n_cmp++; if (if0.grant_cnt[3] !== 16'd1) begin n_err++; $display("FAIL grant_cnt3 got %0d want 1", if0.grant_cnt[3]); end
    n_cmp++; if (if0.starve_grant_cnt !== 16'd1) begin n_err++; $display("FAIL starve_cnt got %0d want 1", if0.starve_grant_cnt); end
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (if0.commit_stall_cnt !== 16'd0) begin n_err++; $display("FAIL stall_clr got %0d want 0", if0.commit_stall_cnt); end
    n_cmp++; if (if0.grant_cnt[3] !== 16'd0) begin n_err++; $display("FAIL grant_clr got %0d want 0", if0.grant_cnt[3]); end
    n_cmp++; if (if0.starve_grant_cnt !== 16'd0) begin n_err++; $display("FAIL starve_clr got %0d want 0", if0.starve_grant_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_commit_starve();
    test_idle();
    test_mid_reset();
    test_starve_override();
    test_random();
`ifdef CDB_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
- Registered, fairness-aware arbiter for the single Common Data Bus (CDB).
- Grants at most one broadcast per cycle among six functional-unit output buffers: adder0, adder1, mult, div, mem, shift.
- A commit packet from the ROB always takes the bus first.
- Among units: round-robin with a starvation override. The winning packet is driven on a registered bus one cycle later.

Parameters:
- STARVE_LIMIT, 8: consecutive waiting cycles after which a valid unit is forced to win. Legal range 1..255.
- AGE_W, $clog2(STARVE_LIMIT+1): width of each per-unit age counter. Derived; not overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- valid_out_bus  in  6  per-unit packet-ready. Bit index: 0 adder0, 1 adder1, 2 mult, 3 div, 4 mem, 5 shift.
- adder_0_out  in  CDB_packet_t  adder0 result packet.
- adder_1_out  in  CDB_packet_t  adder1 result packet.
- mult_out  in  CDB_packet_t  multiplier result packet.
- div_out  in  CDB_packet_t  divider result packet.
- mem_out  in  CDB_packet_t  load result packet.
- shift_out  in  CDB_packet_t  shifter result packet.
- commit_packet  in  CDB_packet_t  ROB commit broadcast. Valid when dest_ROB_entry != 0.
- yummi_in_bus  out  6  one-hot grant, same bit mapping as valid_out_bus. Combinational.
- new_CDB  out  CDB_packet_t  registered bus value.
- rr_ptr_o  out  3  current round-robin start index, 0..5. Debug output.

Behaviour:
- Reset (synchronous):
  - new_CDB is all-zero.
  - rr_ptr resets to 0 and all age counters to 0.
  - yummi_in_bus is forced to 0 while reset is high.
  - Reset asserted mid-stream drops any in-flight grant. The unit keeps its packet because no yummi was issued.
- Grant selection (combinational, evaluated each cycle):
  1. If commit_packet.dest_ROB_entry != 0: commit wins and yummi_in_bus = 0.
  2. Otherwise, if any unit i has valid_out_bus[i] = 1 and age[i] >= STARVE_LIMIT: the lowest such index wins.
  3. Otherwise: the first valid unit found scanning from rr_ptr upward, wrapping 5 -> 0, wins.
  4. Otherwise: no grant.
- Handshake:
  - A yummi bit is asserted only for a unit whose valid bit is high, in the same cycle as that valid.
  - The unit treats valid & yummi as consumed and presents its next packet, or drops valid, on the next cycle.
  - Units must hold packet contents stable while valid is high and yummi is low.
- Output register, latency 1:
  - On commit win: new_CDB <= commit_packet.
  - On unit i win: new_CDB <= unit i packet.
  - On no grant: new_CDB <= all-zero (dest_ROB_entry 0, result 0, branch_result 0, from_commit 0).
- Pointer:
  - On a unit grant to index g: rr_ptr <= (g == 5) ? 0 : g+1. This applies to both round-robin and starvation-override grants.
  - On a commit win or no grant: rr_ptr holds.
- Age counters, per unit i:
  - valid[i] = 0: age <= 0.
  - valid[i] = 1 and granted: age <= 0.
  - valid[i] = 1 and not granted, including cycles lost to commit: age <= min(age+1, STARVE_LIMIT). Saturating; never wraps.
- Simultaneous events:
  - Commit plus starved units: commit still wins, and starved ages stay saturated.
  - Several units starved at once: lowest index wins each cycle until each is cleared.
- Invariants:
  - yummi_in_bus is one-hot or zero.
  - rr_ptr is never 6 or 7.

Optional Feature:
- Macro: CDB_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt[6][16], one counter per unit, incremented on each grant to that unit.
  - Adds output commit_stall_cnt[16], incremented on every cycle where commit wins while valid_out_bus != 0.
  - Adds output starve_grant_cnt[16], incremented on every starvation-override grant.
  - All three are 16-bit, wrap modulo 2^16, and are cleared by reset.
- Undefined: these ports and counters do not exist, and the arbitration logic is identical.

Test Plan:
- Reset with valid_out_bus = 6'b111111 held -> yummi_in_bus = 0 during reset. First cycle after reset: yummi = 6'b000001. Next cycle: new_CDB = adder_0_out, rr_ptr_o = 1.
- All six valid continuously, no commit -> grants cycle 0,1,2,3,4,5,0 one per cycle. new_CDB follows one cycle behind. No age exceeds 5.
- commit_packet.dest_ROB_entry = 4'd3 held for 10 cycles with valid_out_bus = 6'b001000 -> yummi = 0 throughout and new_CDB = commit_packet each cycle. div age saturates at 8. When commit drops: yummi = 6'b001000, and div age returns to 0 the next cycle.
- STARVE_LIMIT = 2, commit held 3 cycles with valid_out_bus = 6'b100010, rr_ptr = 5, then commit cleared -> yummi = 6'b000010: both units starved, lowest index overrides the pointer. rr_ptr_o becomes 2. Next cycle: yummi = 6'b100000.
- No valid and no commit for 4 cycles -> new_CDB all-zero, rr_ptr_o unchanged, yummi = 0.
- CDB_ARB_STATS_EN defined, sequence from the 3rd test -> commit_stall_cnt = 10, grant_cnt[3] = 1, starve_grant_cnt = 1. Reset mid-run -> all three counters read 0.
